// File: rtl/cordic_ctrl_pkg.sv
// rtl/cordic_ctrl_pkg.sv - shared types and constants for the CORDIC sequencing front-end
package cordic_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } ctrl_state_e;

    // Angles on a 32-bit full-scale-is-180-degrees grid
    localparam logic [31:0] ANG_90 = 32'h4000_0000;
    localparam logic [31:0] ANG_60 = 32'h2AAA_AAAB;

    localparam logic SYS_CIRCULAR   = 1'b1;
    localparam logic SYS_HYPERBOLIC = 1'b0;
    localparam logic MODE_ROTATION  = 1'b1;
    localparam logic MODE_VECTORING = 1'b0;

    // Re-express a 32-bit angle constant on a width-bit angle grid (width <= 64)
    function automatic logic [63:0] scale_angle(input logic [31:0] ang, input int width);
        return {ang, 32'h0} >> (64 - width);
    endfunction

endpackage

// File: rtl/cordic_range_check.sv
// rtl/cordic_range_check.sv - combinational operand range check for the CORDIC core
module cordic_range_check
    import cordic_ctrl_pkg::*;
#(
    parameter int p_WIDTH = 32
) (
    input  logic [p_WIDTH-1:0] x,
    input  logic [p_WIDTH-1:0] y,
    input  logic [p_WIDTH-1:0] z,
    input  logic               system,
    input  logic               mode,
    output logic               ok
);

    localparam logic [p_WIDTH:0] LIM_90 = (p_WIDTH+1)'(scale_angle(ANG_90, p_WIDTH));
    localparam logic [p_WIDTH:0] LIM_60 = (p_WIDTH+1)'(scale_angle(ANG_60, p_WIDTH));

    // One extra bit so the magnitude of the most-negative word does not wrap
    function automatic logic [p_WIDTH:0] mag(input logic [p_WIDTH-1:0] v);
        logic [p_WIDTH:0] ext;
        ext = {v[p_WIDTH-1], v};
        return ext[p_WIDTH] ? (~ext + (p_WIDTH+1)'(1)) : ext;
    endfunction

    logic [p_WIDTH:0] mag_x;
    logic [p_WIDTH:0] mag_y;
    logic [p_WIDTH:0] mag_z;

    assign mag_x = mag(x);
    assign mag_y = mag(y);
    assign mag_z = mag(z);

    // Convergence domain of each system/mode pair
    always_comb begin
        ok = 1'b0;
        if (system == SYS_CIRCULAR) begin
            if (mode == MODE_ROTATION) ok = (mag_z <= LIM_90);
            else                       ok = !x[p_WIDTH-1];
        end else begin
            if (mode == MODE_ROTATION) ok = (mag_z <= LIM_60);
            else                       ok = (mag_y < mag_x);
        end
    end

endmodule

// File: rtl/cordic_controller.sv
// rtl/cordic_controller.sv - load/iterate/collect sequencer in front of one iterative CORDIC core
module cordic_controller
    import cordic_ctrl_pkg::*;
#(
    parameter int p_WIDTH    = 32,
    parameter int p_ITERS    = 25,
    parameter int p_INT_BITS = 0
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [p_WIDTH-1:0] in_x,
    input  logic [p_WIDTH-1:0] in_y,
    input  logic [p_WIDTH-1:0] in_z,
    input  logic               in_system,
    input  logic               in_mode,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [p_WIDTH-1:0] out_x,
    output logic [p_WIDTH-1:0] out_y,
    output logic [p_WIDTH-1:0] out_z,
    output logic               out_ovf,
    output logic               out_err,
    output logic [4:0]         out_iters,

    output logic               core_load,
    output logic [p_WIDTH-1:0] core_x,
    output logic [p_WIDTH-1:0] core_y,
    output logic [p_WIDTH-1:0] core_z,
    output logic               core_system,
    output logic               core_mode,
    output logic               core_en,
    output logic [4:0]         core_iter,
    input  logic [p_WIDTH-1:0] core_x_i,
    input  logic [p_WIDTH-1:0] core_y_i,
    input  logic [p_WIDTH-1:0] core_z_i,
    input  logic               core_ovf
);

    if (p_ITERS < 1 || p_ITERS > 31 || p_INT_BITS < 0 || p_INT_BITS >= p_WIDTH) begin : g_bad_params
        $error("cordic_controller: parameter out of range");
    end

    localparam logic [4:0] LAST_ITER = 5'(p_ITERS - 1);

    ctrl_state_e        state;
    logic [p_WIDTH-1:0] lat_x;
    logic [p_WIDTH-1:0] lat_y;
    logic [p_WIDTH-1:0] lat_z;
    logic               lat_system;
    logic               lat_mode;
    logic               load_q;
    logic               en_q;
    logic               en_prev;
    logic [4:0]         iter_cnt;
    logic               range_ok;
    logic               accept;
    logic               ovf_hit;

    cordic_range_check #(
        .p_WIDTH (p_WIDTH)
    ) u_range_check (
        .x      (in_x),
        .y      (in_y),
        .z      (in_z),
        .system (in_system),
        .mode   (in_mode),
        .ok     (range_ok)
    );

    assign accept = in_valid && in_ready;

    // core_ovf only means something in the cycle after a strobe; it must also
    // squash the strobe of that same cycle, so the gating is combinational
    assign ovf_hit = en_prev && core_ovf;

    // Strobes are suppressed in the cycle reset is sampled
    assign core_load   = load_q && !rst;
    assign core_en     = en_q && !ovf_hit && !rst;
    assign core_iter   = iter_cnt;
    assign core_x      = lat_x;
    assign core_y      = lat_y;
    assign core_z      = lat_z;
    assign core_system = lat_system;
    assign core_mode   = lat_mode;

    // The core's final state only settles on the edge that enters DONE and the
    // core stays idle until the next load, so its state is forwarded directly
    assign out_x = out_valid ? (out_err ? lat_x : core_x_i) : '0;
    assign out_y = out_valid ? (out_err ? lat_y : core_y_i) : '0;
    assign out_z = out_valid ? (out_err ? lat_z : core_z_i) : '0;

    // Sequencer: accept, load, iterate until done or overflow, hold result
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            load_q     <= 1'b0;
            en_q       <= 1'b0;
            en_prev    <= 1'b0;
            iter_cnt   <= '0;
            lat_x      <= '0;
            lat_y      <= '0;
            lat_z      <= '0;
            lat_system <= 1'b0;
            lat_mode   <= 1'b0;
            out_valid  <= 1'b0;
            out_err    <= 1'b0;
            out_ovf    <= 1'b0;
            out_iters  <= '0;
        end else begin
            en_prev <= en_q && !ovf_hit;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_x      <= in_x;
                        lat_y      <= in_y;
                        lat_z      <= in_z;
                        lat_system <= in_system;
                        lat_mode   <= in_mode;
                        in_ready   <= 1'b0;
                        out_ovf    <= 1'b0;
                        out_iters  <= '0;
                        if (range_ok) begin
                            out_err <= 1'b0;
                            load_q  <= 1'b1;
                            state   <= LOAD;
                        end else begin
                            out_err   <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                LOAD: begin
                    load_q   <= 1'b0;
                    iter_cnt <= '0;
                    en_q     <= 1'b1;
                    state    <= RUN;
                end
                RUN: begin
                    if (ovf_hit) begin
                        en_q      <= 1'b0;
                        out_ovf   <= 1'b1;
                        out_iters <= iter_cnt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        iter_cnt <= iter_cnt + 5'd1;
                        if (iter_cnt == LAST_ITER) begin
                            en_q      <= 1'b0;
                            out_iters <= 5'(p_ITERS);
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_controller.sv
// tb/tb_cordic_controller.sv - self-checking bench for cordic_controller with a toy core model
module tb_cordic_controller;

    localparam int W     = 32;
    localparam int ITERS = 25;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_x = '0, in_y = '0, in_z = '0;
    logic         in_system = 1'b0, in_mode = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_x, out_y, out_z;
    logic         out_ovf, out_err;
    logic [4:0]   out_iters;
    logic         core_load, core_system, core_mode, core_en;
    logic [W-1:0] core_x, core_y, core_z;
    logic [4:0]   core_iter;
    logic [W-1:0] core_x_i, core_y_i, core_z_i;
    logic         core_ovf = 1'b0;

    always #5 clk = ~clk;

    cordic_controller #(
        .p_WIDTH    (W),
        .p_ITERS    (ITERS),
        .p_INT_BITS (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_z        (in_z),
        .in_system   (in_system),
        .in_mode     (in_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_z       (out_z),
        .out_ovf     (out_ovf),
        .out_err     (out_err),
        .out_iters   (out_iters),
        .core_load   (core_load),
        .core_x      (core_x),
        .core_y      (core_y),
        .core_z      (core_z),
        .core_system (core_system),
        .core_mode   (core_mode),
        .core_en     (core_en),
        .core_iter   (core_iter),
        .core_x_i    (core_x_i),
        .core_y_i    (core_y_i),
        .core_z_i    (core_z_i),
        .core_ovf    (core_ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ovf_after = 0;
    int last_hs  = -10;

    always @(posedge clk) cyc <= cyc + 1;

    // Toy core: each strobe adds iter+1 to x, subtracts 2*iter from y, flips bit iter of z
    logic [W-1:0] cx = '0, cy = '0, cz = '0;
    int strobes = 0;
    always @(posedge clk) begin
        if (core_load) begin
            cx <= core_x; cy <= core_y; cz <= core_z;
            strobes  <= 0;
            core_ovf <= 1'b0;
        end else if (core_en) begin
            cx <= cx + W'(core_iter) + W'(1);
            cy <= cy - W'(2 * int'(core_iter));
            cz <= cz ^ (W'(1) << core_iter);
            strobes  <= strobes + 1;
            core_ovf <= (ovf_after != 0) && (strobes + 1 == ovf_after);
        end else begin
            core_ovf <= 1'b0;
        end
    end
    assign core_x_i = cx;
    assign core_y_i = cy;
    assign core_z_i = cz;

    // Strobe monitor, sampled mid-cycle
    int load_cnt = 0, en_cnt = 0, seq_bad = 0, acc_cycle = 0, load_cyc = 0;
    logic [W-1:0] load_x = '0, load_y = '0, load_z = '0;
    initial forever begin
        @(negedge clk);
        #2;
        if (core_load) begin
            load_cnt++;
            load_cyc = cyc;
            load_x = core_x; load_y = core_y; load_z = core_z;
        end
        if (core_en) begin
            if (core_iter != 5'(en_cnt) || cyc != acc_cycle + 2 + en_cnt) seq_bad++;
            en_cnt++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_ok(input logic [W-1:0] x, y, z, input logic s, m);
        longint ax, ay, az;
        ax = longint'($signed(x)); if (ax < 0) ax = -ax;
        ay = longint'($signed(y)); if (ay < 0) ay = -ay;
        az = longint'($signed(z)); if (az < 0) az = -az;
        if (s && m)  return az <= 64'h4000_0000;
        if (s && !m) return $signed(x) >= 0;
        if (!s && m) return az <= 64'h2AAA_AAAB;
        return ay < ax;
    endfunction

    task automatic check_reset_state(input string ph);
        check({ph, "_in_ready"},  64'(in_ready), 64'd1);
        check({ph, "_out_valid"}, 64'(out_valid), 64'd0);
        check({ph, "_strobes"},   64'({core_load, core_en}), 64'd0);
        check({ph, "_flags"},     64'({out_ovf, out_err}), 64'd0);
        check({ph, "_out_data"},  64'(|{out_x, out_y, out_z}), 64'd0);
        check({ph, "_core_data"}, 64'(|{core_x, core_y, core_z}), 64'd0);
        check({ph, "_iters"},     64'({out_iters, core_iter}), 64'd0);
        check({ph, "_sys_mode"},  64'({core_system, core_mode}), 64'd0);
    endtask

    task automatic present(input logic [W-1:0] x, y, z, input logic s, m);
        in_x = x; in_y = y; in_z = z; in_system = s; in_mode = m;
        in_valid = 1'b1;
    endtask

    // One request through to its result handshake; called and returns on a negedge
    task automatic do_op(input logic [W-1:0] x, y, z, input logic s, m,
                         input int ovf_at, input int hold, input bit chain,
                         input logic [W-1:0] nx, ny, nz, input logic ns, nm,
                         input bit expect_b2b);
        bit ok, ovf, stable;
        int n, lat, guard, hs;
        logic [W-1:0] ex, ey, ez;
        logic [3*W+7:0] snap;
        ok = ref_ok(x, y, z, s, m);
        if (!ok)                              begin n = 0;      ovf = 0; end
        else if (ovf_at > 0 && ovf_at < ITERS) begin n = ovf_at; ovf = 1; end
        else                                  begin n = ITERS;  ovf = 0; end
        lat = !ok ? 1 : (ovf ? n + 3 : n + 2);
        if (!ok) begin
            ex = x; ey = y; ez = z;
        end else begin
            ex = x + W'(n * (n + 1) / 2);
            ey = y - W'(n * (n - 1));
            ez = z ^ W'((64'd1 << n) - 64'd1);
        end
        ovf_after = ovf_at;
        present(x, y, z, s, m);
        guard = 0;
        while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
        check("accept_wait", 64'(in_ready), 64'd1);
        if (expect_b2b) check("b2b_accept_cycle", 64'(cyc), 64'(last_hs + 1));
        acc_cycle = cyc; load_cnt = 0; en_cnt = 0; seq_bad = 0;
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_in_ready", 64'(in_ready), 64'd0);
        guard = 0;
        while (!out_valid && guard < 100) begin @(negedge clk); guard++; end
        check("latency",   64'(cyc - acc_cycle), 64'(lat));
        check("out_err",   64'(out_err), 64'(!ok));
        check("out_ovf",   64'(out_ovf), 64'(ovf));
        check("out_iters", 64'(out_iters), 64'(n));
        check("out_x",     64'(out_x), 64'(ex));
        check("out_y",     64'(out_y), 64'(ey));
        check("out_z",     64'(out_z), 64'(ez));
        check("load_count", 64'(load_cnt), 64'(ok ? 1 : 0));
        check("en_count",  64'(en_cnt), 64'(n));
        check("en_sequence_errors", 64'(seq_bad), 64'd0);
        if (ok) check("load_cycle_data",
                      64'(load_cyc == acc_cycle + 1 && load_x == x && load_y == y && load_z == z),
                      64'd1);
        check("core_sys_mode", 64'({core_system, core_mode}), 64'({s, m}));
        if (chain) present(nx, ny, nz, ns, nm);
        snap = {out_x, out_y, out_z, out_err, out_ovf, out_iters, in_ready};
        stable = 1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if ({out_x, out_y, out_z, out_err, out_ovf, out_iters, in_ready} !== snap || out_valid !== 1'b1)
                stable = 0;
        end
        if (hold > 0) check("backpressure_stable", 64'(stable), 64'd1);
        out_ready = 1'b1;
        hs = cyc;
        @(negedge clk);
        out_ready = 1'b0;
        last_hs = hs;
        check("released", 64'({out_valid, in_ready}), 64'b01);
    endtask

    function automatic logic [W-1:0] pick_ang();
        case ($urandom_range(0, 7))
            0:       return 32'h4000_0000;
            1:       return 32'hC000_0000;
            2:       return 32'h4000_0001;
            3:       return 32'h8000_0000;
            4:       return 32'h2AAA_AAAB;
            5:       return 32'hD555_5555;
            6:       return 32'h2AAA_AAAC;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int guard, en_before;
        logic [W-1:0] rx, ry, rz;
        logic rs, rm;

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // Circular rotation, 45 degrees, full run
        do_op(32'h4DBA_76D4, 32'h0, 32'h2000_0000, 1'b1, 1'b1, 0, 0, 0, '0, '0, '0, 1'b0, 1'b0, 0);
        // Circular rotation at 120 degrees is rejected
        do_op(32'h4DBA_76D4, 32'h0, 32'h5555_5555, 1'b1, 1'b1, 0, 0, 0, '0, '0, '0, 1'b0, 1'b0, 0);
        // Hyperbolic vectoring: |y| > |x| and |y| == |x| both rejected
        do_op(32'h2000_0000, 32'h4000_0000, 32'h0, 1'b0, 1'b0, 0, 0, 0, '0, '0, '0, 1'b0, 1'b0, 0);
        do_op(32'h2000_0000, 32'hE000_0000, 32'h0, 1'b0, 1'b0, 0, 0, 0, '0, '0, '0, 1'b0, 1'b0, 0);
        // Overflow reported after the 7th strobe
        do_op(32'h1000_0000, 32'h0300_0000, 32'h0, 1'b1, 1'b1, 7, 0, 0, '0, '0, '0, 1'b0, 1'b0, 0);
        // Backpressure for 10 cycles with the next request waiting during DONE
        do_op(32'h0123_4567, 32'h0011_2233, 32'hC000_0000, 1'b1, 1'b1, 0, 10, 1,
              32'h3000_0000, 32'h1000_0000, 32'h2AAA_AAAB, 1'b0, 1'b1, 0);
        do_op(32'h3000_0000, 32'h1000_0000, 32'h2AAA_AAAB, 1'b0, 1'b1, 0, 0, 0,
              '0, '0, '0, 1'b0, 1'b0, 1);

        // Reset in the middle of a run
        ovf_after = 0;
        present(32'h1234_5678, 32'h0765_4321, 32'h1000_0000, 1'b1, 1'b1);
        guard = 0;
        while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
        acc_cycle = cyc; load_cnt = 0; en_cnt = 0; seq_bad = 0;
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (!(core_en && core_iter == 5'd12) && guard < 100) begin @(negedge clk); guard++; end
        check("reach_iter12", 64'({core_en, core_iter}), 64'({1'b1, 5'd12}));
        rst = 1'b1;
        #1;
        check("no_strobe_in_reset_cycle", 64'({core_load, core_en}), 64'd0);
        @(negedge clk);
        check_reset_state("midrun_reset");
        rst = 1'b0;
        en_before = en_cnt;
        repeat (5) @(negedge clk);
        check("no_en_after_reset", 64'(en_cnt), 64'(en_before));
        do_op(32'h0200_0000, 32'h0100_0000, 32'h0, 1'b0, 1'b0, 0, 1, 0, '0, '0, '0, 1'b0, 1'b0, 0);

        // Randomized operations
        for (int i = 0; i < 14; i++) begin
            rs = 1'($urandom_range(0, 1));
            rm = 1'($urandom_range(0, 1));
            rx = W'($urandom) >> $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) rx = -rx;
            case ($urandom_range(0, 3))
                0:       ry = rx;
                1:       ry = -rx;
                default: ry = W'($urandom) >> $urandom_range(0, 3);
            endcase
            rz = pick_ang();
            do_op(rx, ry, rz, rs, rm,
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, ITERS - 1)) : 0,
                  int'($urandom_range(0, 3)), 0, '0, '0, '0, 1'b0, 1'b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
